// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one combinational signed multiplier
// among N_REQ requesters, with operand capture, registered product and one-hot ack.

// Combinational full-precision signed multiplier shared by all requesters
module multb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] p
);

   localparam int unsigned PW = 2 * WIDTH;

   // Sign-extend both operands to product width so the product is exact
   always_comb begin
      p = PW'(a) * PW'(b);
   end

endmodule

module mult_share_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*WIDTH-1:0]      a_bus,
   input  logic [N_REQ*WIDTH-1:0]      b_bus,
   output logic [N_REQ-1:0]            gnt,
   output logic                        busy,
   output logic [N_REQ-1:0]            ack,
   output logic                        res_valid,
   output logic [$clog2(N_REQ)-1:0]    res_id,
   output logic signed [2*WIDTH-1:0]   result
);

   localparam int unsigned ID_W = $clog2(N_REQ);
   localparam int unsigned PW   = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   logic [ID_W-1:0]         last;
   logic [ID_W-1:0]         owner;
   logic signed [WIDTH-1:0] op_a;
   logic signed [WIDTH-1:0] op_b;
   logic signed [PW-1:0]    prod;

   logic signed [WIDTH-1:0] a_arr [N_REQ];
   logic signed [WIDTH-1:0] b_arr [N_REQ];

   logic                    win_found;
   logic [ID_W-1:0]         win_idx;
   logic [ID_W-1:0]         cand;

   // Unpack the flat operand buses into per-requester words
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         a_arr[i] = a_bus[i*WIDTH +: WIDTH];
         b_arr[i] = b_bus[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin pick: first pending request after the last served slot
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((32'(last) + k) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   multb #(
      .WIDTH (WIDTH)
   ) u_multb (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   // Operation sequencer: capture in IDLE, register product in MULT, retire in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= ID_W'(N_REQ - 1);
         owner     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         ack       <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         result    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  op_a  <= a_arr[win_idx];
                  op_b  <= b_arr[win_idx];
                  owner <= win_idx;
                  gnt   <= N_REQ'(1) << win_idx;
                  busy  <= 1'b1;
                  state <= MULT;
               end
            end
            MULT: begin
               result    <= prod;
               ack       <= N_REQ'(1) << owner;
               res_valid <= 1'b1;
               res_id    <= owner;
               state     <= DONE;
            end
            DONE: begin
               ack       <= '0;
               res_valid <= 1'b0;
               gnt       <= '0;
               busy      <= 1'b0;
               last      <= owner;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed scoreboard bench for the shared multiplier arbiter.
module tb_mult_share_arbiter;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned WIDTH = 8;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] res;
   } exp_t;

   logic                   clk;
   logic                   rst;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] a_bus;
   logic [N_REQ*WIDTH-1:0] b_bus;
   logic [N_REQ-1:0]       gnt;
   logic                   busy;
   logic [N_REQ-1:0]       ack;
   logic                   res_valid;
   logic [1:0]             res_id;
   logic [15:0]            result;

   exp_t       sb [$];
   int         ack_cyc [$];
   logic [3:0] hold;
   int         cyc;
   int         n_checks;
   int         n_fail;

   mult_share_arbiter #(
      .N_REQ (N_REQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_bus     (a_bus),
      .b_bus     (b_bus),
      .gnt       (gnt),
      .busy      (busy),
      .ack       (ack),
      .res_valid (res_valid),
      .res_id    (res_id),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $fatal(1, "FAIL global_timeout: simulation did not finish");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int id, input int p);
      exp_t e;
      e.id  = 2'(id);
      e.res = 16'(p);
      sb.push_back(e);
   endtask

   task automatic set_ops(input int id, input int a, input int b);
      a_bus[id*WIDTH +: WIDTH] = 8'(a);
      b_bus[id*WIDTH +: WIDTH] = 8'(b);
   endtask

   task automatic wait_done(input string tag, input int bound);
      int k;
      k = 0;
      while (sb.size() != 0 && k < bound) begin
         next();
         k++;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic single(input int id, input int a, input int b);
      set_ops(id, a, b);
      req[id] = 1'b1;
      push_exp(id, a * b);
      wait_done("single_drain", 12);
   endtask

   task automatic check_spacing(input string tag, input int n);
      check({tag, "_count"}, 32'(ack_cyc.size()), 32'(n));
      for (int i = 1; i < ack_cyc.size(); i++) begin
         check({tag, "_gap"}, 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      end
   endtask

   // Result monitor: compares against the scoreboard and retires owner requests
   always @(negedge clk) begin
      if (res_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_id", 32'(res_id), 32'(e.id));
            check("result", 32'(result), 32'(e.res));
            check("ack_onehot", 32'(ack), 32'(4'b0001 << e.id));
            ack_cyc.push_back(cyc);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (ack[i] && !hold[i]) req[i] = 1'b0;
         end
      end
   end

   initial begin
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      hold     = 4'b0000;
      rst      = 1'b1;
      req      = '0;
      a_bus    = '0;
      b_bus    = '0;
      repeat (3) next();

      // Reset state
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      rst = 1'b0;

      // Single request from requester 1
      set_ops(1, 7, 11);
      req = 4'b0010;
      push_exp(1, 77);
      next();
      check("t1_gnt", 32'(gnt), 32'h2);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_ack_early", 32'(ack), 32'd0);
      next();
      check("t1_ack", 32'(ack), 32'h2);
      check("t1_res_valid", 32'(res_valid), 32'd1);
      check("t1_result", 32'(result), 32'd77);
      next();
      check("t1_busy_low", 32'(busy), 32'd0);
      check("t1_gnt_low", 32'(gnt), 32'd0);
      check("t1_ack_low", 32'(ack), 32'd0);
      check("t1_drain", 32'(sb.size()), 32'd0);

      // All four at once after reset: served 0,1,2,3 three cycles apart
      rst = 1'b1;
      next();
      rst = 1'b0;
      ack_cyc.delete();
      for (int i = 0; i < N_REQ; i++) begin
         set_ops(i, 7 * i, 11 * i);
         push_exp(i, 77 * i * i);
      end
      req = 4'b1111;
      wait_done("t2_drain", 20);
      check_spacing("t2", 4);

      // Signed corner products
      single(0, -128, -128);
      single(1, -128, 127);
      single(2, -1, 1);
      single(3, 0, -5);

      // Fairness: req0 held, req2 raised mid-op; grants alternate 0,2,0,2
      ack_cyc.delete();
      hold = 4'b0101;
      set_ops(0, 3, 5);
      req[0] = 1'b1;
      push_exp(0, 15);
      next();
      set_ops(2, -2, 9);
      req[2] = 1'b1;
      push_exp(2, -18);
      push_exp(0, 15);
      push_exp(2, -18);
      wait_done("t4_drain", 20);
      req  = '0;
      hold = 4'b0000;
      check_spacing("t4", 4);
      next();
      next();
      check("t4_idle_busy", 32'(busy), 32'd0);

      // Owner drops req during MULT with new operands: captured operands used
      set_ops(3, -7, 6);
      req[3] = 1'b1;
      push_exp(3, -42);
      next();
      req[3] = 1'b0;
      set_ops(3, 100, 100);
      wait_done("t5_drain", 10);

      // Reset during MULT discards the op; pending req1 then req3
      set_ops(1, 5, 5);
      set_ops(3, -3, -4);
      req = 4'b1010;
      next();
      check("t6_gnt_before_rst", 32'(gnt), 32'h2);
      rst = 1'b1;
      next();
      check("t6_gnt", 32'(gnt), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_ack", 32'(ack), 32'd0);
      check("t6_res_valid", 32'(res_valid), 32'd0);
      check("t6_res_id", 32'(res_id), 32'd0);
      check("t6_result", 32'(result), 32'd0);
      rst = 1'b0;
      push_exp(1, 25);
      push_exp(3, 12);
      wait_done("t6_drain", 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
